// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg -- shared definitions for the dmem arbiter slice.
//   ADDR_W_DEF / DATA_W_DEF   : default dmem address / data widths
//   STARVE_LIMIT_DEF          : default loader starvation threshold
//   CNT_W_DEF                 : default conflict counter width
//   WAIT_W                    : width of the loader wait counter
//   gnt_e                     : one-hot-ish grant encoding (none / P / L)
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 12;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 3;
  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned WAIT_W           = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_P    = 2'b01,
    GNT_L    = 2'b10
  } gnt_e;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter -- counts consecutive cycles the loader has asked for
// dmem without being served, saturating at STARVE_LIMIT.
//   clock       : master clock, rising edge
//   reset       : asynchronous, active-low
//   req         : loader request
//   gnt         : loader granted this cycle
//   force_grant : wait count has reached STARVE_LIMIT; the loader must win
//                 the next contended cycle
module arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic force_grant
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_cnt;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (gnt) begin
      wait_cnt <= '0;
    end else if (req) begin
      if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      // Loader withdrew its request; starvation history no longer applies.
      wait_cnt <= '0;
    end
  end

  assign force_grant = (wait_cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares the single-port dmem between the processor (P) and
// the loader/debug port (L). P has fixed priority; L is forced through after
// STARVE_LIMIT consecutive denied cycles. dmem runs on the inverted clock, so
// read data appears on mem_q one clock after the granted address.
//   clock, reset                      : master clock / async active-low reset
//   p_req,p_wren,p_addr,p_data        : processor request
//   p_gnt,p_rvalid,p_q,p_stall        : processor grant, read return, stall
//   l_req,l_wren,l_addr,l_data        : loader request
//   l_gnt,l_rvalid,l_q                : loader grant, read return
//   mem_address,mem_data,mem_wren     : to dmem
//   mem_q                             : from dmem
//   conflicts                         : saturating count of contended cycles
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_q,
  input  logic              l_req,
  input  logic              l_wren,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_data,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_q,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              p_stall,
  output logic [CNT_W-1:0]  conflicts
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  gnt_e gnt_sel;
  logic force_l;

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock       (clock),
    .reset       (reset),
    .req         (l_req),
    .gnt         (l_gnt),
    .force_grant (force_l)
  );

  // Grants are combinational and suppressed while reset is asserted so dmem
  // sees no access during reset.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    gnt_sel = GNT_NONE;
    if (reset) begin
      if (p_req && l_req) gnt_sel = force_l ? GNT_L : GNT_P;
      else if (p_req)     gnt_sel = GNT_P;
      else if (l_req)     gnt_sel = GNT_L;
    end
  end

  assign p_gnt = (gnt_sel == GNT_P);
  assign l_gnt = (gnt_sel == GNT_L);

  // The processor is held in reset too, so the stall is only meaningful
  // once reset is released.
  assign p_stall = reset & p_req & ~p_gnt;

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    case (gnt_sel)
      GNT_P: begin
        mem_address = p_addr;
        mem_data    = p_data;
        mem_wren    = p_wren;
      end
      GNT_L: begin
        mem_address = l_addr;
        mem_data    = l_data;
        mem_wren    = l_wren;
      end
      default: ;
    endcase
  end

  // Read-valid pipeline and saturating conflict counter. The two rvalids are
  // independent, so alternating back-to-back grants overlap cleanly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_rvalid  <= 1'b0;
      l_rvalid  <= 1'b0;
      conflicts <= '0;
    end else begin
      p_rvalid <= p_gnt & ~p_wren;
      l_rvalid <= l_gnt & ~l_wren;
      if (p_req && l_req && conflicts != CNT_MAX)
        conflicts <= conflicts + CNT_W'(1);
    end
  end

  assign p_q = p_rvalid ? mem_q : '0;
  assign l_q = l_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- randomized and directed bench for dmem_arbiter with a
// behavioural dmem (inverted clock) and a reference model kept in the bench.
module tb_dmem_arbiter;

  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 3;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
  localparam int DEPTH        = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              p_req = 1'b0, p_wren = 1'b0;
  logic [ADDR_W-1:0] p_addr = '0;
  logic [DATA_W-1:0] p_data = '0;
  logic              l_req = 1'b0, l_wren = 1'b0;
  logic [ADDR_W-1:0] l_addr = '0;
  logic [DATA_W-1:0] l_data = '0;
  logic              p_gnt, p_rvalid, l_gnt, l_rvalid, mem_wren, p_stall;
  logic [DATA_W-1:0] p_q, l_q, mem_data;
  logic [DATA_W-1:0] mem_q = '0;
  logic [ADDR_W-1:0] mem_address;
  logic [CNT_W-1:0]  conflicts;

  dmem_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT), .CNT_W (CNT_W)
  ) dut (
    .clock (clock), .reset (reset),
    .p_req (p_req), .p_wren (p_wren), .p_addr (p_addr), .p_data (p_data),
    .p_gnt (p_gnt), .p_rvalid (p_rvalid), .p_q (p_q),
    .l_req (l_req), .l_wren (l_wren), .l_addr (l_addr), .l_data (l_data),
    .l_gnt (l_gnt), .l_rvalid (l_rvalid), .l_q (l_q),
    .mem_address (mem_address), .mem_data (mem_data), .mem_wren (mem_wren),
    .mem_q (mem_q), .p_stall (p_stall), .conflicts (conflicts)
  );

  always #5 clock = ~clock;

  // Behavioural dmem: single-port syncram on the inverted clock.
  logic [DATA_W-1:0] dmem   [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];

  always @(negedge clock) begin
    if (mem_wren) dmem[mem_address] <= mem_data;
    mem_q <= dmem[mem_address];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          waits    = 0;
  int          exp_conf = 0;
  bit          p_pend   = 1'b0, l_pend = 1'b0;
  logic [31:0] p_pdata  = '0,   l_pdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    waits    = 0;
    exp_conf = 0;
    p_pend   = 1'b0;
    l_pend   = 1'b0;
  endtask

  task automatic idle_inputs();
    p_req = 1'b0; p_wren = 1'b0; p_addr = '0; p_data = '0;
    l_req = 1'b0; l_wren = 1'b0; l_addr = '0; l_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p_gnt"},    32'(p_gnt),       32'd0);
    check({tag, "_l_gnt"},    32'(l_gnt),       32'd0);
    check({tag, "_p_rvalid"}, 32'(p_rvalid),    32'd0);
    check({tag, "_l_rvalid"}, 32'(l_rvalid),    32'd0);
    check({tag, "_p_q"},      p_q,              32'd0);
    check({tag, "_l_q"},      l_q,              32'd0);
    check({tag, "_mem_addr"}, 32'(mem_address), 32'd0);
    check({tag, "_mem_data"}, mem_data,         32'd0);
    check({tag, "_mem_wren"}, 32'(mem_wren),    32'd0);
    check({tag, "_p_stall"},  32'(p_stall),     32'd0);
    check({tag, "_conflict"}, 32'(conflicts),   32'd0);
  endtask

  // Assert reset with random inputs toggling; everything must read zero.
  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p_req = 1'(($urandom)); p_wren = 1'(($urandom));
      p_addr = ADDR_W'($urandom); p_data = $urandom;
      l_req = 1'(($urandom)); l_wren = 1'(($urandom));
      l_addr = ADDR_W'($urandom); l_data = $urandom;
      #1;
      check_all_zero("rst");
      @(posedge clock); #1;
    end
    clear_model();
    idle_inputs();
    reset = 1'b1;
  endtask

  // One bus cycle: drive, compare against the model, advance the model and
  // the clock. Entered and left 1 time unit after a rising edge. Returns the
  // grants the DUT actually gave.
  task automatic step(input logic pr, input logic pw, input logic [ADDR_W-1:0] pa,
                      input logic [DATA_W-1:0] pd, input logic lr, input logic lw,
                      input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                      output logic dut_p, output logic dut_l);
    logic        ep, el, ewren;
    logic [31:0] eaddr, edata;
    p_req = pr; p_wren = pw; p_addr = pa; p_data = pd;
    l_req = lr; l_wren = lw; l_addr = la; l_data = ld;
    #1;
    // Loader wins only when alone or after STARVE_LIMIT denied cycles.
    el    = lr && (!pr || waits == STARVE_LIMIT);
    ep    = pr && !el;
    eaddr = ep ? 32'(pa) : el ? 32'(la) : 32'd0;
    edata = ep ? pd : el ? ld : 32'd0;
    ewren = ep ? pw : el ? lw : 1'b0;
    check("p_gnt",    32'(p_gnt),       32'(ep));
    check("l_gnt",    32'(l_gnt),       32'(el));
    check("p_stall",  32'(p_stall),     32'(pr && !ep));
    check("mem_addr", 32'(mem_address), eaddr);
    check("mem_data", mem_data,         edata);
    check("mem_wren", 32'(mem_wren),    32'(ewren));
    check("p_rvalid", 32'(p_rvalid),    32'(p_pend));
    check("p_q",      p_q,              p_pend ? p_pdata : 32'd0);
    check("l_rvalid", 32'(l_rvalid),    32'(l_pend));
    check("l_q",      l_q,              l_pend ? l_pdata : 32'd0);
    check("conflict", 32'(conflicts),   32'(exp_conf));
    dut_p = p_gnt;
    dut_l = l_gnt;
    // Advance the model to the next edge.
    p_pend  = ep && !pw;
    p_pdata = shadow[pa];
    l_pend  = el && !lw;
    l_pdata = shadow[la];
    if (ep && pw) shadow[pa] = pd;
    if (el && lw) shadow[la] = ld;
    if (el)      waits = 0;
    else if (lr) waits = (waits < STARVE_LIMIT) ? waits + 1 : STARVE_LIMIT;
    else         waits = 0;
    if (pr && lr && exp_conf < CNT_MAX) exp_conf++;
    @(posedge clock); #1;
  endtask

  logic        gp, gl;
  logic        rp_req, rp_wren, rl_req, rl_wren;
  logic [11:0] rp_addr, rl_addr;
  logic [31:0] rp_data, rl_data;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      dmem[i]   = 32'(i) * 32'h9E37_79B1;
      shadow[i] = 32'(i) * 32'h9E37_79B1;
    end
    @(posedge clock); #1;

    // Reset, then idle with no requests.
    do_reset();
    step(0, 0, '0, '0, 0, 0, '0, '0, gp, gl);
    step(0, 0, '0, '0, 0, 0, '0, '0, gp, gl);

    // Processor read of 0x010, returned one cycle later.
    step(1, 0, 12'h010, '0, 0, 0, '0, '0, gp, gl);
    step(0, 0, '0, '0, 0, 0, '0, '0, gp, gl);

    // Loader write 0xFFF then read it back.
    step(0, 0, '0, '0, 1, 1, 12'hFFF, 32'hDEADBEEF, gp, gl);
    check("l_rvalid_after_write", 32'(l_rvalid), 32'd0);
    step(0, 0, '0, '0, 1, 0, 12'hFFF, '0, gp, gl);
    check("l_q_fff", l_q, 32'hDEADBEEF);
    step(0, 0, '0, '0, 0, 0, '0, '0, gp, gl);

    // Continuous contention: P,P,P,L,P,P,P,L.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 12'h020, '0, 1, 0, 12'h030, '0, gp, gl);
      check("contention_l_gnt", 32'(gl), 32'((i % 4) == 3));
      check("contention_p_gnt", 32'(gp), 32'((i % 4) != 3));
    end
    check("contention_conflicts", 32'(conflicts), 32'd8);
    step(0, 0, '0, '0, 0, 0, '0, '0, gp, gl);

    // Reset arriving while a processor read is outstanding.
    do_reset();
    step(1, 0, 12'h040, '0, 0, 0, '0, '0, gp, gl);
    check("pre_reset_p_rvalid", 32'(p_rvalid), 32'd1);
    p_req = 1'b1; p_wren = 1'b0; p_addr = 12'h041;
    #1;
    check("pre_reset_p_gnt", 32'(p_gnt), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_reset_p_rvalid", 32'(p_rvalid), 32'd0);
    check("mid_reset_p_gnt",    32'(p_gnt),    32'd0);
    check("mid_reset_mem_wren", 32'(mem_wren), 32'd0);
    @(posedge clock); #1;
    check("post_edge_p_rvalid", 32'(p_rvalid), 32'd0);
    check("post_edge_mem_wren", 32'(mem_wren), 32'd0);
    clear_model();
    idle_inputs();
    reset = 1'b1;
    step(0, 0, '0, '0, 0, 0, '0, '0, gp, gl);

    // Randomized traffic; each requester holds its request until granted.
    do_reset();
    rp_req = 1'b0; rp_wren = 1'b0; rp_addr = '0; rp_data = '0;
    rl_req = 1'b0; rl_wren = 1'b0; rl_addr = '0; rl_data = '0;
    for (int i = 0; i < 400; i++) begin
      if (!rp_req || gp) begin
        rp_req  = ($urandom_range(0, 99) < 60);
        rp_wren = 1'($urandom);
        rp_addr = 12'($urandom_range(0, 15));
        rp_data = $urandom;
      end
      if (!rl_req || gl) begin
        rl_req  = ($urandom_range(0, 99) < 50);
        rl_wren = 1'($urandom);
        rl_addr = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
        rl_data = $urandom;
      end
      gp = 1'b0; gl = 1'b0;
      step(rp_req, rp_wren, rp_addr, rp_data, rl_req, rl_wren, rl_addr, rl_data, gp, gl);
    end
    step(0, 0, '0, '0, 0, 0, '0, '0, gp, gl);

    // Conflict counter saturation.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1, 0, 12'h050, '0, 1, 0, 12'h060, '0, gp, gl);
    check("conflicts_saturated", 32'(conflicts), 32'(CNT_MAX));
    step(0, 0, '0, '0, 0, 0, '0, '0, gp, gl);
    check("conflicts_hold", 32'(conflicts), 32'(CNT_MAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
